// File: rtl/hp_manager.sv
// Hit-point tracker for a two-player match: applies damage and streak bonuses when the
// controller enters a result state, and reports depletion status back to the controller.
module hp_manager #(
    parameter int unsigned HP_MAX      = 5,
    parameter int unsigned HPW         = 4,
    parameter int unsigned DMG         = 1,
    parameter int unsigned CRIT_DMG    = 2,
    parameter int unsigned STREAK_CRIT = 3
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [3:0]     STATE,
    input  logic           NEW_GAME,
    output logic [1:0]     HP_OUT,
    output logic [HPW-1:0] HP_SELF,
    output logic [HPW-1:0] HP_OPP,
    output logic [2:0]     STREAK,
    output logic [3:0]     ROUND,
    output logic [1:0]     HIT,
    output logic           GAME_OVER
);

    localparam logic [3:0] ST_READY    = 4'b0010;
    localparam logic [3:0] ST_QUESTION = 4'b0011;
    localparam logic [3:0] ST_DRAW     = 4'b0110;
    localparam logic [3:0] ST_WRONG    = 4'b0111;
    localparam logic [3:0] ST_GOOD     = 4'b1000;
    localparam logic [3:0] ST_OUCH     = 4'b1001;

    localparam logic [HPW-1:0] L_HP_MAX   = HPW'(HP_MAX);
    localparam logic [HPW-1:0] L_DMG      = HPW'(DMG);
    localparam logic [HPW-1:0] L_CRIT_DMG = HPW'(CRIT_DMG);
    localparam logic [2:0]     L_CRIT_AT  = 3'(STREAK_CRIT);

    logic [3:0]     r_prev_state;
    logic [HPW-1:0] r_hp_self, r_hp_opp;
    logic [2:0]     r_streak;
    logic [3:0]     r_round;
    logic [1:0]     r_hit, r_hp_out;
    logic           r_game_over;

    logic           w_entry, w_reload;
    logic [HPW-1:0] w_self_nxt, w_opp_nxt;
    logic [2:0]     w_streak_nxt, w_streak_inc;
    logic [3:0]     w_round_nxt;
    logic [1:0]     w_hit_nxt, w_hp_out_nxt;

    function automatic logic [HPW-1:0] sat_sub(input logic [HPW-1:0] a,
                                               input logic [HPW-1:0] d);
        return (a > d) ? a - d : '0;
    endfunction

    always_comb begin
        w_entry      = (STATE != r_prev_state);
        w_reload     = (STATE == ST_READY) && NEW_GAME;
        w_streak_inc = (r_streak == 3'd7) ? 3'd7 : r_streak + 3'd1;
        w_self_nxt   = r_hp_self;
        w_opp_nxt    = r_hp_opp;
        w_streak_nxt = r_streak;
        w_round_nxt  = r_round;
        w_hit_nxt    = 2'b00;
        if (w_entry) begin
            // Round counting continues after the match is decided; damage does not.
            if (STATE == ST_QUESTION) begin
                w_round_nxt = r_round + 4'd1;
            end
            if (!r_game_over) begin
                case (STATE)
                    ST_GOOD: begin
                        w_streak_nxt = w_streak_inc;
                        w_opp_nxt    = sat_sub(r_hp_opp,
                                               (w_streak_inc >= L_CRIT_AT) ? L_CRIT_DMG : L_DMG);
                        w_hit_nxt    = 2'b10;
                    end
                    ST_OUCH: begin
                        w_self_nxt   = sat_sub(r_hp_self, L_DMG);
                        w_streak_nxt = 3'd0;
                        w_hit_nxt    = 2'b01;
                    end
                    ST_DRAW: begin
                        w_self_nxt   = sat_sub(r_hp_self, L_DMG);
                        w_opp_nxt    = sat_sub(r_hp_opp, L_DMG);
                        w_streak_nxt = 3'd0;
                        w_hit_nxt    = 2'b11;
                    end
                    ST_WRONG: w_streak_nxt = 3'd0;
                    default: ;
                endcase
            end
        end
        w_hp_out_nxt = {w_self_nxt == '0, w_opp_nxt == '0};
    end

    // Reload shares the reset path; both leave prev_state at READY.
    always_ff @(posedge CLK) begin
        if (!RST || w_reload) begin
            r_prev_state <= ST_READY;
            r_hp_self    <= L_HP_MAX;
            r_hp_opp     <= L_HP_MAX;
            r_streak     <= 3'd0;
            r_round      <= 4'd0;
            r_hit        <= 2'b00;
            r_hp_out     <= 2'b00;
            r_game_over  <= 1'b0;
        end else begin
            r_prev_state <= STATE;
            r_hp_self    <= w_self_nxt;
            r_hp_opp     <= w_opp_nxt;
            r_streak     <= w_streak_nxt;
            r_round      <= w_round_nxt;
            r_hit        <= w_hit_nxt;
            r_hp_out     <= w_hp_out_nxt;
            r_game_over  <= r_game_over | (w_hp_out_nxt != 2'b00);
        end
    end

    assign HP_OUT    = r_hp_out;
    assign HP_SELF   = r_hp_self;
    assign HP_OPP    = r_hp_opp;
    assign STREAK    = r_streak;
    assign ROUND     = r_round;
    assign HIT       = r_hit;
    assign GAME_OVER = r_game_over;

endmodule
